ball_ctrl: RTL

//  Per-frame ball motion sequencer for the pong datapath. Owns x/y position regs fed
//  to draw_ball; handles serve delay, wall bounces, paddle bounces and miss/score

---
 rtl/ball_ctrl.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/ball_ctrl.sv
// Per-frame ball motion sequencer: serve delay, wall/paddle bounces, miss detection.
// Optional build macro BALL_SPEEDUP_EN: each paddle bounce adds 1 px/frame up to MAX_SPEED.
module ball_ctrl #(
  parameter int SIZE_OF_BALL = 15,
  parameter int H_RES        = 1024,
  parameter int V_RES        = 768,
  parameter int PADDLE_W     = 10,
  parameter int PADDLE_H     = 96,
  parameter int L_PADDLE_X   = 32,
  parameter int R_PADDLE_X   = 982,
  parameter int SERVE_FRAMES = 60,
  parameter int INIT_SPEED   = 2,
  parameter int MAX_SPEED    = 7
) (
  input  logic        clk65MHz,
  input  logic        rst,
  input  logic        vblnk,
  input  logic        screen_idle,
  input  logic        start,
  input  logic [10:0] y_pos_paddle_l,
  input  logic [10:0] y_pos_paddle_r,
  output logic [10:0] x_pos_of_ball,
  output logic [10:0] y_pos_of_ball,
  output logic        score_l,
  output logic        score_r,
  output logic        in_play
);

  localparam int CW = $clog2(SERVE_FRAMES + 1);

  localparam logic [11:0] XC      = 12'((H_RES - SIZE_OF_BALL) / 2);
  localparam logic [11:0] YC      = 12'((V_RES - SIZE_OF_BALL) / 2);
  localparam logic [11:0] SZ      = 12'(SIZE_OF_BALL);
  localparam logic [11:0] HR      = 12'(H_RES);
  localparam logic [11:0] Y_LIM   = 12'(V_RES - 1 - SIZE_OF_BALL);
  localparam logic [11:0] PH      = 12'(PADDLE_H);
  localparam logic [11:0] L_EDGE  = 12'(L_PADDLE_X + PADDLE_W);
  localparam logic [11:0] R_EDGE  = 12'(R_PADDLE_X);
  localparam logic [11:0] R_STOP  = 12'(R_PADDLE_X - SIZE_OF_BALL);
  localparam logic [3:0]  SPD0    = 4'(INIT_SPEED);
  localparam logic [3:0]  SPD_MAX = 4'(MAX_SPEED);
  localparam logic [CW-1:0] CNT_LAST = CW'(SERVE_FRAMES - 1);

`ifdef BALL_SPEEDUP_EN
  localparam bit SPEEDUP = 1'b1;
`else
  localparam bit SPEEDUP = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, SERVE, MOVE, SCORE} state_t;

  state_t        state, state_n;
  logic          vblnk_q, tick;
  logic [11:0]   x, y, x_n, y_n;
  logic          dir_x, dir_y, serve_dir;        // dir_x 1=right, dir_y 1=down
  logic          dir_x_n, dir_y_n, serve_dir_n;
  logic [3:0]    speed, speed_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          score_l_n, score_r_n;

  logic [11:0] spd, xn_r, xn_l, yn_u, yn_d, pl, pr;
  logic        ovl_l, ovl_r, hit_r, hit_l, miss_r, miss_l, speed_bump;

  assign tick = vblnk & ~vblnk_q;
  assign spd  = {8'd0, speed};
  assign xn_r = x + spd;
  assign xn_l = x - spd;
  assign yn_u = y - spd;
  assign yn_d = y + spd;
  assign pl   = {1'b0, y_pos_paddle_l};
  assign pr   = {1'b0, y_pos_paddle_r};

  // Overlap uses the pre-step y so both paddles see the same ball row this frame.
  assign ovl_l  = (y + SZ > pl) && (y < pl + PH);
  assign ovl_r  = (y + SZ > pr) && (y < pr + PH);
  assign hit_r  = dir_x && (xn_r + SZ >= R_EDGE) && ovl_r;
  assign hit_l  = !dir_x && (x >= L_EDGE) && (xn_l <= L_EDGE) && ovl_l;
  assign miss_r = dir_x && (xn_r + SZ >= HR);
  assign miss_l = !dir_x && (x < spd);
  assign speed_bump = SPEEDUP && (speed < SPD_MAX);

  always_ff @(posedge clk65MHz) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n     = state;
    x_n         = x;
    y_n         = y;
    dir_x_n     = dir_x;
    dir_y_n     = dir_y;
    serve_dir_n = serve_dir;
    speed_n     = speed;
    cnt_n       = cnt;
    score_l_n   = 1'b0;
    score_r_n   = 1'b0;

    case (state)
      IDLE: begin
        x_n   = XC;
        y_n   = YC;
        cnt_n = '0;
        if (start) state_n = SERVE;
      end

      SERVE: begin
        x_n     = XC;
        y_n     = YC;
        dir_x_n = serve_dir;
        dir_y_n = 1'b1;
        speed_n = SPD0;
        if (tick) begin
          if (cnt == CNT_LAST) begin
            cnt_n   = '0;
            state_n = MOVE;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      end

      MOVE: if (tick) begin
        // Floor bounce fires as soon as the step would reach the last visible row.
        if (!dir_y) begin
          if (y < spd) begin
            y_n     = '0;
            dir_y_n = 1'b1;
          end else begin
            y_n = yn_u;
          end
        end else if (yn_d >= Y_LIM) begin
          y_n     = Y_LIM;
          dir_y_n = 1'b0;
        end else begin
          y_n = yn_d;
        end

        if (hit_r) begin
          x_n     = R_STOP;
          dir_x_n = 1'b0;
          speed_n = speed + {3'd0, speed_bump};
        end else if (hit_l) begin
          x_n     = L_EDGE;
          dir_x_n = 1'b1;
          speed_n = speed + {3'd0, speed_bump};
        end else if (miss_r) begin
          score_l_n = 1'b1;
          state_n   = SCORE;
        end else if (miss_l) begin
          score_r_n = 1'b1;
          state_n   = SCORE;
        end else begin
          x_n = dir_x ? xn_r : xn_l;
        end
      end

      SCORE: begin
        cnt_n = '0;
        if (tick) begin
          x_n         = XC;
          y_n         = YC;
          serve_dir_n = ~serve_dir;
          state_n     = SERVE;
        end
      end

      default: state_n = IDLE;
    endcase

    if (screen_idle) begin
      state_n   = IDLE;
      x_n       = XC;
      y_n       = YC;
      cnt_n     = '0;
      score_l_n = 1'b0;
      score_r_n = 1'b0;
    end
  end

  always_ff @(posedge clk65MHz) begin
    if (rst) begin
      vblnk_q   <= 1'b0;
      x         <= XC;
      y         <= YC;
      dir_x     <= 1'b1;
      dir_y     <= 1'b1;
      serve_dir <= 1'b1;
      speed     <= SPD0;
      cnt       <= '0;
      score_l   <= 1'b0;
      score_r   <= 1'b0;
      in_play   <= 1'b0;
    end else begin
      vblnk_q   <= vblnk;
      x         <= x_n;
      y         <= y_n;
      dir_x     <= dir_x_n;
      dir_y     <= dir_y_n;
      serve_dir <= serve_dir_n;
      speed     <= speed_n;
      cnt       <= cnt_n;
      score_l   <= score_l_n;
      score_r   <= score_r_n;
      in_play   <= (state_n == SERVE) || (state_n == MOVE);
    end
  end

  assign x_pos_of_ball = x[10:0];
  assign y_pos_of_ball = y[10:0];

endmodule
